crtc_timing: RTL and testbench
==============================

Name: crtc_timing

Overview:
- 6845/6545-style video timing generator. It is the consumer (reader) side of the CRTC register file that the CPU writes at $E8xx.
- Takes the live R0..R15 contents and produces character-rate memory address, row address, sync and display-enable signals for the video fetch/shift path.
- Runs in the system clock domain. It advances only on a one-cycle character-clock enable.
- Non-interlaced only; R8 is ignored.

Parameters:
MA_WIDTH, 14, width of ma output and start/cursor address arithmetic
ROW_WIDTH, 7, width of character-row counter (R4/R6/R7 compare width)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
cclk_en  input  1  character-clock enable; one pulse advances one character
crtc_regs  input  128  R0..R15 flattened; Rn = crtc_regs[8n+7:8n]; sampled live
ma  output  MA_WIDTH  video memory address of current character
ra  output  5  scanline within character row
h_sync  output  1  horizontal sync, active high
v_sync  output  1  vertical sync, active high
de  output  1  display enable
cursor  output  1  cursor active for current character (see Optional Feature)

Behaviour:
- All state and outputs are registered. Update only on clk edges where cclk_en=1; with cclk_en=0, everything holds.
- Reset (async, reset_n=0): all outputs are 0; counters are 0; FSM = START; frame counter is 0.
- FSM states: START, ROWS, ADJUST.
- START: the first cclk_en loads h=0, ra=0, row=0, ma_row=ma={R12[5:0],R13}, then goes to ROWS. Outputs reflect char 0 on that same edge.
- Horizontal: h (8b) increments per cclk_en. When h==R0, next h=0 (end of line). Line period is R0+1 chars.
- h_de: 1 for h<R1. R1=0 means never on. R1>R0 means on for the whole line.
- h_sync: rises on the char where h==R2 and lasts W chars, W=R3[3:0] (0 means 16). It may straddle the line wrap. A new match while active restarts the width count.
- ma: ma_row+h during the line, computed mod 2^MA_WIDTH.
- End of line in ROWS: if ra!=R9[4:0], ra++. Otherwise ra=0, ma_row+=R1, and row++ unless row==R4[6:0].
- When row==R4 and ra==R9 at end of line:
  - If R5[4:0]!=0: go to ADJUST with ra=0.
  - Otherwise: frame end.
- ADJUST: at end of each line ra++. When ra==R5-1, frame end.
- ADJUST: de is forced to 0. ma continues ma_row+h.
- Frame end:
  - h=0, ra=0, row=0.
  - ma_row={R12,R13} are re-latched; this is the only point they are read.
  - Frame counter (5b) increments.
  - State = ROWS.
- v_de: 1 while row<R6[6:0] in ROWS. de = h_de & v_de.
- v_sync:
  - Rises at scanline 0 of row==R7[6:0] (including row 0 at frame end).
  - Lasts V scanlines, V=R3[7:4] (0 means 16), counted at line ends.
  - Continues across frame end if still active.
- Register changes take effect at the next compare. No shadowing except R12/R13.
- R9 > 31 cannot occur (5b field). ra compares use == only, so a register lowered mid-row causes ra to run to 31 and wrap to 0 at the 5b boundary.

Optional Feature:
- Macro: CRTC_CURSOR_EN.
- Enabled:
  - cursor=1 when ma=={R14[5:0],R15}, R10[4:0] <= ra <= R11[4:0], de=1, and blink is on.
  - Blink by R10[6:5]: 00 steady on; 01 off; 10 on when frame_cnt[3]==0; 11 on when frame_cnt[4]==0.
- Disabled: cursor tied to 0; R10/R11/R14/R15 unused; no frame counter.

Decomposition:
- Package crtc_pkg holds:
  - Register index localparams R_H_TOTAL=0 … R_CURSOR_L=15.
  - Fsm enum {START, ROWS, ADJUST}.
  - Sync-width decode function (0 maps to 16).
  - PET reset default values, shared with the register file.
- One natural sub-module, crtc_sync_pulse: a start-match/width-down-counter instanced for h_sync (char rate) and v_sync (line rate).

Test Plan:
- PET defaults (R0=31h, R1=28h, R2=29h, R3=0Fh, R4=28h, R5=05h, R6=19h, R7=21h, R9=07h, R12=10h, R13=00h), cclk_en every clk -> line period 50; h_sync high for h=41..55 mod 50 (15 chars); de high h=0..39.
- Same config -> ma=1000h..1027h on rows 0 ra 0..7; row 1 starts at 1028h; de lines = 200; frame period 41*8+5 = 333 lines = 16650 cclk.
- Same config -> v_sync rises at line 264 (row 33), lasts 16 lines; ADJUST lines 328..332 have ra 0..4 and de=0.
- R12=3Fh, R13=F0h, R1=28h -> ma runs 3FF0h..3FFFh, then 0000h..0017h, no glitch; cclk_en held low 10 clk -> all outputs frozen.
- reset_n pulsed low mid-line -> outputs 0 asynchronously; first cclk_en after release -> h=0, ma=1000h, de=1.
- CRTC_CURSOR_EN, R14=10h, R15=05h, R10=06h, R11=07h -> cursor only at ma=1005h, ra 6..7. R10=46h -> cursor present frames 0..7, absent 8..15.

Source files
------------

// File: rtl/crtc_pkg.sv
// crtc_pkg: shared definitions for the CRTC timing generator and register file.
// Register indices, FSM encoding, sync-width decode and PET power-on register values.
package crtc_pkg;

    localparam int R_H_TOTAL    = 0;
    localparam int R_H_DISP     = 1;
    localparam int R_H_SYNC_POS = 2;
    localparam int R_SYNC_WIDTH = 3;
    localparam int R_V_TOTAL    = 4;
    localparam int R_V_ADJ      = 5;
    localparam int R_V_DISP     = 6;
    localparam int R_V_SYNC_POS = 7;
    localparam int R_MODE       = 8;
    localparam int R_MAX_RA     = 9;
    localparam int R_CUR_START  = 10;
    localparam int R_CUR_END    = 11;
    localparam int R_START_H    = 12;
    localparam int R_START_L    = 13;
    localparam int R_CURSOR_H   = 14;
    localparam int R_CURSOR_L   = 15;

    typedef enum logic [1:0] {
        START  = 2'd0,
        ROWS   = 2'd1,
        ADJUST = 2'd2
    } crtc_state_e;

    // PET defaults, R15 down to R0
    localparam logic [127:0] PET_REGS_DEFAULT = {
        8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h07, 8'h00,
        8'h21, 8'h19, 8'h05, 8'h28, 8'h0F, 8'h29, 8'h28, 8'h31
    };

    // 4-bit sync width field: zero encodes the maximum width of 16
    function automatic logic [4:0] sync_width(input logic [3:0] w);
        return (w == 4'd0) ? 5'd16 : {1'b0, w};
    endfunction

endpackage

// File: rtl/crtc_sync_pulse.sv
// crtc_sync_pulse: start-match / width down-counter used for both h_sync
// (advanced per character) and v_sync (advanced per scanline).
module crtc_sync_pulse (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       adv,
    input  logic       match,
    input  logic [4:0] width,
    output logic       active
);

    logic [4:0] rem;
    logic [4:0] rem_n;

    // rem counts units left including the one being entered; a match restarts it
    always_comb begin
        rem_n = rem;
        if (match)
            rem_n = width;
        else if (rem != 5'd0)
            rem_n = rem - 5'd1;
    end

    // update only when the owning counter steps to a new char/line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem    <= '0;
            active <= 1'b0;
        end else if (adv) begin
            rem    <= rem_n;
            active <= (rem_n != 5'd0);
        end
    end

endmodule

// File: rtl/crtc_timing.sv
// crtc_timing: 6845/6545-style non-interlaced video timing generator.
// Reads live R0..R15, advances one character per cclk_en pulse.
// Optional cursor/blink logic is built when CRTC_CURSOR_EN is defined.
module crtc_timing
    import crtc_pkg::*;
#(
    parameter int MA_WIDTH  = 14,
    parameter int ROW_WIDTH = 7
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cclk_en,
    input  logic [127:0]        crtc_regs,
    output logic [MA_WIDTH-1:0] ma,
    output logic [4:0]          ra,
    output logic                h_sync,
    output logic                v_sync,
    output logic                de,
    output logic                cursor
);

    // register fields
    logic [7:0]           r_htot, r_hdisp, r_hsp, r_sw;
    logic [ROW_WIDTH-1:0] r_vtot, r_vdisp, r_vsp;
    logic [4:0]           r_vadj, r_maxra;
    logic [MA_WIDTH-1:0]  start_addr;

    assign r_htot     = crtc_regs[8*R_H_TOTAL    +: 8];
    assign r_hdisp    = crtc_regs[8*R_H_DISP     +: 8];
    assign r_hsp      = crtc_regs[8*R_H_SYNC_POS +: 8];
    assign r_sw       = crtc_regs[8*R_SYNC_WIDTH +: 8];
    assign r_vtot     = crtc_regs[8*R_V_TOTAL    +: ROW_WIDTH];
    assign r_vdisp    = crtc_regs[8*R_V_DISP     +: ROW_WIDTH];
    assign r_vsp      = crtc_regs[8*R_V_SYNC_POS +: ROW_WIDTH];
    assign r_vadj     = crtc_regs[8*R_V_ADJ      +: 5];
    assign r_maxra    = crtc_regs[8*R_MAX_RA     +: 5];
    assign start_addr = MA_WIDTH'({crtc_regs[8*R_START_H +: 6], crtc_regs[8*R_START_L +: 8]});

    // R8 and the unused high bits of several fields are intentionally ignored
    logic unused_regs;
    assign unused_regs = ^crtc_regs;

    crtc_state_e          state, state_n;
    logic [7:0]           h, h_n;
    logic [4:0]           ra_n;
    logic [ROW_WIDTH-1:0] row, row_n;
    logic [MA_WIDTH-1:0]  ma_row, ma_row_n, ma_n;
    logic                 eol, line_adv, frame_end;
    logic                 de_n, cursor_n;

    // equality only: a register lowered below the counter lets it wrap naturally
    assign eol = (h == r_htot);

    // character / scanline / row sequencing
    always_comb begin
        state_n   = state;
        h_n       = h;
        ra_n      = ra;
        row_n     = row;
        ma_row_n  = ma_row;
        line_adv  = 1'b0;
        frame_end = 1'b0;
        case (state)
            START: begin
                state_n  = ROWS;
                h_n      = '0;
                ra_n     = '0;
                row_n    = '0;
                ma_row_n = start_addr;
                line_adv = 1'b1;
            end
            ROWS: begin
                if (eol) begin
                    line_adv = 1'b1;
                    h_n      = '0;
                    if (ra != r_maxra) begin
                        ra_n = ra + 5'd1;
                    end else begin
                        ra_n     = '0;
                        ma_row_n = ma_row + MA_WIDTH'(r_hdisp);
                        if (row != r_vtot)
                            row_n = row + ROW_WIDTH'(1);
                        else if (r_vadj != 5'd0)
                            state_n = ADJUST;
                        else
                            frame_end = 1'b1;
                    end
                end else begin
                    h_n = h + 8'd1;
                end
            end
            ADJUST: begin
                if (eol) begin
                    line_adv = 1'b1;
                    h_n      = '0;
                    if (ra == r_vadj - 5'd1)
                        frame_end = 1'b1;
                    else
                        ra_n = ra + 5'd1;
                end else begin
                    h_n = h + 8'd1;
                end
            end
            default: state_n = START;
        endcase
        // start address is only re-read here, giving a frame-stable shadow of R12/R13
        if (frame_end) begin
            state_n  = ROWS;
            h_n      = '0;
            ra_n     = '0;
            row_n    = '0;
            ma_row_n = start_addr;
        end
    end

    // outputs for the character being entered
    assign ma_n = ma_row_n + MA_WIDTH'(h_n);
    assign de_n = (h_n < r_hdisp) && (state_n == ROWS) && (row_n < r_vdisp);

    crtc_sync_pulse u_hsync (
        .clk     (clk),
        .reset_n (reset_n),
        .adv     (cclk_en),
        .match   (h_n == r_hsp),
        .width   (sync_width(r_sw[3:0])),
        .active  (h_sync)
    );

    crtc_sync_pulse u_vsync (
        .clk     (clk),
        .reset_n (reset_n),
        .adv     (cclk_en && line_adv),
        .match   ((state_n == ROWS) && (ra_n == 5'd0) && (row_n == r_vsp)),
        .width   (sync_width(r_sw[7:4])),
        .active  (v_sync)
    );

`ifdef CRTC_CURSOR_EN
    logic [4:0]          frame_cnt, frame_cnt_n;
    logic [MA_WIDTH-1:0] cur_addr;
    logic [4:0]          r_cstart, r_cend;
    logic                blink_on;

    assign frame_cnt_n = frame_end ? frame_cnt + 5'd1 : frame_cnt;
    assign cur_addr    = MA_WIDTH'({crtc_regs[8*R_CURSOR_H +: 6], crtc_regs[8*R_CURSOR_L +: 8]});
    assign r_cstart    = crtc_regs[8*R_CUR_START +: 5];
    assign r_cend      = crtc_regs[8*R_CUR_END   +: 5];

    // blink mode in R10[6:5], judged against the frame being entered
    always_comb begin
        case (crtc_regs[8*R_CUR_START+5 +: 2])
            2'b00:   blink_on = 1'b1;
            2'b01:   blink_on = 1'b0;
            2'b10:   blink_on = ~frame_cnt_n[3];
            default: blink_on = ~frame_cnt_n[4];
        endcase
    end

    assign cursor_n = blink_on && de_n && (ma_n == cur_addr) &&
                      (ra_n >= r_cstart) && (ra_n <= r_cend);

    // frame counter drives blink phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            frame_cnt <= '0;
        else if (cclk_en)
            frame_cnt <= frame_cnt_n;
    end
`else
    assign cursor_n = 1'b0;
`endif

    // state and registered outputs, frozen while cclk_en is low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= START;
            h      <= '0;
            ra     <= '0;
            row    <= '0;
            ma_row <= '0;
            ma     <= '0;
            de     <= 1'b0;
            cursor <= 1'b0;
        end else if (cclk_en) begin
            state  <= state_n;
            h      <= h_n;
            ra     <= ra_n;
            row    <= row_n;
            ma_row <= ma_row_n;
            ma     <= ma_n;
            de     <= de_n;
            cursor <= cursor_n;
        end
    end

endmodule

// File: tb/tb_crtc_timing.sv
// tb_crtc_timing: scoreboard + table-driven bench for crtc_timing.
// Expected values come from closed-form frame models written per test config.
module tb_crtc_timing;
    import crtc_pkg::*;

`ifdef CRTC_CURSOR_EN
    localparam bit CUR_EN = 1'b1;
`else
    localparam bit CUR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         cclk_en = 1'b0;
    logic [127:0] regs;
    logic [13:0]  ma;
    logic [4:0]   ra;
    logic         h_sync, v_sync, de, cursor;

    crtc_timing #(.MA_WIDTH(14), .ROW_WIDTH(7)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cclk_en   (cclk_en),
        .crtc_regs (regs),
        .ma        (ma),
        .ra        (ra),
        .h_sync    (h_sync),
        .v_sync    (v_sync),
        .de        (de),
        .cursor    (cursor)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0] ma;
        logic [4:0]  ra;
        logic        hs;
        logic        vs;
        logic        de;
        logic        cur;
    } obs_t;

    typedef struct {
        int   n;
        obs_t exp;
    } vec_t;

    obs_t sb_q[$];
    vec_t vecs[16];
    int   nv = 0;
    int   tests = 0;
    int   fails = 0;
    int   n = 0;

    // PET frame: 50 chars/line, 41 rows x 8 lines + 5 adjust lines
    function automatic obs_t pet_model(input int c, input logic [13:0] start);
        obs_t o;
        int ln, hc, lf, row, r;
        ln = c / 50;
        hc = c % 50;
        lf = ln % 333;
        if (lf < 328) begin
            row = lf / 8;
            r   = lf % 8;
        end else begin
            row = 41;
            r   = lf - 328;
        end
        o.ma  = 14'(int'(start) + row * 40 + hc);
        o.ra  = 5'(r);
        o.hs  = (hc >= 41) || (hc <= 5 && c >= 50);
        o.vs  = (lf >= 264) && (lf < 280);
        o.de  = (hc < 40) && (lf < 200);
        o.cur = 1'b0;
        return o;
    endfunction

    // tiny frame: 10 chars/line, 2 rows x 8 lines, no adjust, syncs never match
    function automatic obs_t tiny_model(input int c, input bit blink);
        obs_t o;
        int ln, hc, lf, fr;
        ln = c / 10;
        hc = c % 10;
        lf = ln % 16;
        fr = ln / 16;
        o.ma  = 14'(32'h1000 + (lf / 8) * 8 + hc);
        o.ra  = 5'(lf % 8);
        o.hs  = 1'b0;
        o.vs  = 1'b0;
        o.de  = (hc < 8);
        o.cur = CUR_EN && (hc == 5) && (lf >= 6) && (lf <= 7) && (!blink || (fr % 16) < 8);
        return o;
    endfunction

    function automatic vec_t mk(input int c, input logic [13:0] m, input int r,
                                input bit hs, input bit vs, input bit d);
        vec_t v;
        v.n   = c;
        v.exp = {m, 5'(r), hs, vs, d, 1'b0};
        return v;
    endfunction

    task automatic check(input string nm);
        obs_t e, a;
        tests++;
        a = {ma, ra, h_sync, v_sync, de, cursor};
        if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL %s n=%0d scoreboard empty", nm, n);
        end else begin
            e = sb_q.pop_front();
            if (a !== e) begin
                fails++;
                $display("FAIL %s n=%0d got ma=%h ra=%0d hs=%b vs=%b de=%b cur=%b want ma=%h ra=%0d hs=%b vs=%b de=%b cur=%b",
                         nm, n, a.ma, a.ra, a.hs, a.vs, a.de, a.cur,
                         e.ma, e.ra, e.hs, e.vs, e.de, e.cur);
            end
        end
    endtask

    task automatic tick(input obs_t e, input string nm);
        sb_q.push_back(e);
        cclk_en = 1'b1;
        @(posedge clk);
        #1;
        check(nm);
    endtask

    task automatic reset_pulse();
        cclk_en = 1'b0;
        #2 reset_n = 1'b0;
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog n=%0d", n);
        $fatal(1, "watchdog");
    end

    initial begin
        regs = PET_REGS_DEFAULT;
        vecs[nv++] = mk(0,     14'h1000, 0, 0, 0, 1);
        vecs[nv++] = mk(39,    14'h1027, 0, 0, 0, 1);
        vecs[nv++] = mk(40,    14'h1028, 0, 0, 0, 0);
        vecs[nv++] = mk(41,    14'h1029, 0, 1, 0, 0);
        vecs[nv++] = mk(50,    14'h1000, 1, 1, 0, 1);
        vecs[nv++] = mk(55,    14'h1005, 1, 1, 0, 1);
        vecs[nv++] = mk(56,    14'h1006, 1, 0, 0, 1);
        vecs[nv++] = mk(400,   14'h1028, 0, 1, 0, 1);
        vecs[nv++] = mk(10000, 14'h13E8, 0, 1, 0, 0);
        vecs[nv++] = mk(13200, 14'h1528, 0, 1, 1, 0);
        vecs[nv++] = mk(13960, 14'h155A, 7, 0, 1, 0);
        vecs[nv++] = mk(14000, 14'h1578, 0, 1, 0, 0);
        vecs[nv++] = mk(16400, 14'h1668, 0, 1, 0, 0);
        vecs[nv++] = mk(16603, 14'h166B, 4, 1, 0, 0);
        vecs[nv++] = mk(16650, 14'h1000, 0, 1, 0, 1);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        sb_q.push_back('0);
        check("reset");
        reset_n = 1'b1;

        // full PET frame with spot vectors
        for (int v = 0; v < nv; v++) begin
            while (n <= vecs[v].n) begin
                tick(pet_model(n, 14'h1000), "pet");
                n++;
            end
            sb_q.push_back(vecs[v].exp);
            check("vec");
        end
        while (n < 16700) begin
            tick(pet_model(n, 14'h1000), "pet");
            n++;
        end

        // cclk_en low: everything holds
        cclk_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sb_q.push_back(pet_model(n - 1, 14'h1000));
            @(posedge clk);
            #1;
            check("freeze");
        end
        for (int i = 0; i < 5; i++) begin
            tick(pet_model(n, 14'h1000), "resume");
            n++;
        end

        // asynchronous reset mid-line
        cclk_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        sb_q.push_back('0);
        check("async_rst");
        @(posedge clk);
        #1;
        sb_q.push_back('0);
        check("rst_hold");
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(pet_model(n, 14'h1000), "post_rst");
            n++;
        end

        // start address near top of the address space wraps cleanly
        regs[8*R_START_H +: 8] = 8'h3F;
        regs[8*R_START_L +: 8] = 8'hF0;
        reset_pulse();
        for (int i = 0; i < 60; i++) begin
            tick(pet_model(n, 14'h3FF0), "wrap");
            n++;
        end

        // small frame for cursor and blink across 18 frames
        regs = PET_REGS_DEFAULT;
        regs[8*R_H_TOTAL    +: 8] = 8'h09;
        regs[8*R_H_DISP     +: 8] = 8'h08;
        regs[8*R_H_SYNC_POS +: 8] = 8'hFF;
        regs[8*R_V_TOTAL    +: 8] = 8'h01;
        regs[8*R_V_ADJ      +: 8] = 8'h00;
        regs[8*R_V_DISP     +: 8] = 8'h02;
        regs[8*R_V_SYNC_POS +: 8] = 8'h7F;
        regs[8*R_CUR_START  +: 8] = 8'h06;
        regs[8*R_CUR_END    +: 8] = 8'h07;
        regs[8*R_CURSOR_H   +: 8] = 8'h10;
        regs[8*R_CURSOR_L   +: 8] = 8'h05;
        reset_pulse();
        while (n < 2880) begin
            if (n == 320)
                regs[8*R_CUR_START +: 8] = 8'h46;
            tick(tiny_model(n, n >= 320), "cursor");
            n++;
        end

        cclk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
